core_dmem_resp: RTL and testbench
=================================

Name: core_dmem_resp

Overview:
- Data-memory responder: the memory-side end of the core's load/store port.
- Accepts one request at a time from the core over a valid/ready handshake.
- Performs byte/half/word writes with byte enables, and aligned loads with sign or zero extension.
- Returns a single-cycle response. Contains the data RAM array.

Parameters:
- ADDR_W, 12, word-address bits; the array holds 2**ADDR_W 32-bit words.
- LATENCY, 0, extra wait cycles inserted before the array access; legal range 0..15.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  responder can accept a request.
- REQ_ADDR  in  32  byte address.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- REQ_UNSIGNED  in  1  load zero-extends (lbu/lhu); ignored for word accesses and stores.
- REQ_WDATA  in  32  store data; byte for lane i is taken from bits [8i+7:8i], so lane-replicated data is valid.
- RESP_VALID  out  1  one-cycle response strobe.
- RESP_RDATA  out  32  extended load data; 0 for stores and errors.
- RESP_ERR  out  1  misaligned, reserved-size or out-of-range request; valid with RESP_VALID.

Behaviour:
- Clock is CLK; reset is RST, asynchronous and active-high. Reset values:
  - state IDLE, wait counter 0.
  - RESP_VALID 0, RESP_RDATA 0, RESP_ERR 0.
  - REQ_READY forced 0 while RST is high.
  - Array contents are not reset.
- FSM states and transitions:
  - IDLE: REQ_READY = 1. On REQ_VALID, latch all REQ_* fields and go to WAIT if LATENCY > 0, else to ACCESS.
  - WAIT: count LATENCY cycles, then go to ACCESS. REQ_VALID is ignored.
  - ACCESS: on the next edge, write the enabled bytes (stores, no error) or register the read word (loads). Compute the error flag. Go to RESP.
  - RESP: RESP_VALID = 1 for exactly this cycle with RDATA/ERR. Go to IDLE on the next edge.
- Latency: a request accepted at edge t0 gives RESP_VALID high in the cycle after edge t0+2+LATENCY. Minimum request spacing is 3+LATENCY cycles.
- No response backpressure: the initiator must sample RESP_VALID.
- REQ_READY is 0 outside IDLE. Requests offered then are not accepted; the initiator holds them.
- Byte enables, with a = latched addr[1:0]:
  - byte: 1<<a.
  - half: a=0 gives 0011, a=2 gives 1100.
  - word: 1111.
- Error conditions (all respond at normal latency):
  - half with a[0]=1, word with a!=0, or size 11.
  - addr[31:ADDR_W+2] nonzero (out of range).
  - On error: no array write and RDATA = 0.
- Load result: the read word is shifted right by 8*a.
  - byte: bits [7:0], extended from bit 7 (sign) or with zeros per UNSIGNED.
  - half: bits [15:0], extended from bit 15 likewise.
  - word: unmodified.
- Store response: RESP_VALID=1, RDATA=0, ERR per the error rules.
- Reset mid-operation: FSM returns to IDLE immediately and any in-flight response is dropped.
  - A store is only written at the ACCESS edge.
  - If RST rises before that edge, the write is suppressed: the write enable is gated by state==ACCESS, which reset clears.
- Read-after-write: the store completes before its RESP, so a following load to the same address returns the new data.

Decomposition:
- Package core_mem_pkg: SIZE_B/SIZE_H/SIZE_W/SIZE_RSV encodings and the FSM state encodings (IDLE, WAIT, ACCESS, RESP).
- Sub-module core_dmem_align (combinational), instantiated twice (store path and load path):
  - store path: size + addr[1:0] -> 4-bit byte enable + misalign flag.
  - load path: word + addr[1:0] + size + unsigned -> extended load data.
- The array and FSM live in core_dmem_resp.

Test Plan:
- LATENCY=0, store word 0x11223344 to 0x100, then load word from 0x100 -> RESP_VALID 2 cycles after each accept edge, RDATA=0x11223344, ERR=0.
- Store byte 0xAA (replicated 0xAAAAAAAA) to 0x102 over the word above, then lb 0x102 -> 0xFFFFFFAA; lbu 0x102 -> 0x000000AA; lw 0x100 -> 0x11AA3344.
- sh 0x8001 to 0x106, then lh 0x106 -> 0xFFFF8001, lhu -> 0x00008001; lh 0x105 -> ERR=1, RDATA=0, no memory change.
- Address 0x00010000 with ADDR_W=12 -> ERR=1; size 11 -> ERR=1; both at normal latency.
- LATENCY=3: REQ_VALID held high continuously -> REQ_READY low for 5 cycles after accept, RESP_VALID 5 cycles after the accept edge, next accept one cycle later.
- Assert RST during WAIT of a store sw 0xDEADBEEF to 0x200 -> no RESP_VALID, REQ_READY=0 during reset then 1, and a later lw 0x200 returns the prior value.

Source files
------------

// File: rtl/core_mem_pkg.sv
// core_mem_pkg: access-size and FSM state encodings shared by the data-memory responder
// Ports: none (package only)
package core_mem_pkg;
    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
endpackage

// File: rtl/core_dmem_align.sv
// core_dmem_align: byte-lane alignment for loads and stores
// Ports: size/addr_lo/uns/word in; be (byte enables), misalign, data (extended load word) out
module core_dmem_align
    import core_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic        misalign,
    output logic [31:0] data
);
    logic [31:0] sh;
    always_comb begin
        be = size == SIZE_B ? 4'b0001 << addr_lo :
             size == SIZE_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
             size == SIZE_W ? 4'b1111 : 4'b0000;
        misalign = size == SIZE_H ? addr_lo[0] :
                   size == SIZE_W ? |addr_lo : size == SIZE_RSV;
        sh = word >> {addr_lo, 3'b000};
        data = size == SIZE_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
               size == SIZE_H ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
    end
endmodule

// File: rtl/core_dmem_resp.sv
// core_dmem_resp: memory-side responder for the core load/store port, holds the data RAM
// Ports: CLK/RST; REQ_VALID/READY handshake with ADDR, WE, SIZE, UNSIGNED, WDATA;
//        registered RESP_VALID strobe with RESP_RDATA and RESP_ERR
module core_dmem_resp
    import core_mem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [31:0] REQ_ADDR,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_UNSIGNED,
    input  logic [31:0] REQ_WDATA,
    output logic        RESP_VALID,
    output logic [31:0] RESP_RDATA,
    output logic        RESP_ERR
);
    state_t state, nxt;
    logic [3:0] cnt;
    logic [31:0] addr_q, wdata_q, rword, ld_data;
    logic we_q, uns_q, err_q, err, wr, misalign;
    logic [1:0] size_q;
    logic [3:0] be;
    logic [3:0] unused_be;
    logic unused_mis;
    logic [31:0] unused_data;
    logic [31:0] mem [2**ADDR_W];
    wire [ADDR_W-1:0] idx = addr_q[ADDR_W+1:2];

    core_dmem_align u_st (
        .size(size_q), .addr_lo(addr_q[1:0]), .uns(1'b0), .word(32'd0),
        .be(be), .misalign(misalign), .data(unused_data)
    );
    core_dmem_align u_ld (
        .size(size_q), .addr_lo(addr_q[1:0]), .uns(uns_q), .word(rword),
        .be(unused_be), .misalign(unused_mis), .data(ld_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SIZE_B;
            err_q      <= 1'b0;
            RESP_VALID <= 1'b0;
            RESP_RDATA <= '0;
            RESP_ERR   <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= state == WAIT ? cnt + 4'd1 : 4'd0;
            if (REQ_READY && REQ_VALID) begin
                addr_q  <= REQ_ADDR;
                wdata_q <= REQ_WDATA;
                we_q    <= REQ_WE;
                uns_q   <= REQ_UNSIGNED;
                size_q  <= REQ_SIZE;
            end
            if (state == ACCESS) err_q <= err;
            RESP_VALID <= state == RESP;
            RESP_ERR   <= state == RESP && err_q;
            RESP_RDATA <= (state == RESP && !err_q && !we_q) ? ld_data : '0;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (REQ_VALID) nxt = LATENCY > 0 ? WAIT : ACCESS;
            WAIT:    if (cnt == 4'(LATENCY - 1)) nxt = ACCESS;
            ACCESS:  nxt = RESP;
            default: nxt = IDLE;
        endcase
    end

    // Reset clears state asynchronously, so a store caught by reset before its ACCESS edge never writes.
    always_comb begin
        REQ_READY = state == IDLE && !RST;
        err       = misalign || |addr_q[31:ADDR_W+2];
        wr        = state == ACCESS && we_q && !err;
    end

    always_ff @(posedge CLK) begin
        if (state == ACCESS) rword <= mem[idx];
        for (int i = 0; i < 4; i++)
            if (wr && be[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_core_dmem_resp.sv
module tb_core_dmem_resp;
    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic v[2], we[2], un[2], rdy[2], rv[2], re[2];
    logic [1:0] sz[2];
    logic [31:0] a[2], wd[2], rd[2];
    exp_t q0[$], q1[$];
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    core_dmem_resp #(.ADDR_W(12), .LATENCY(0)) d0 (
        .CLK(clk), .RST(rst), .REQ_VALID(v[0]), .REQ_READY(rdy[0]), .REQ_ADDR(a[0]),
        .REQ_WE(we[0]), .REQ_SIZE(sz[0]), .REQ_UNSIGNED(un[0]), .REQ_WDATA(wd[0]),
        .RESP_VALID(rv[0]), .RESP_RDATA(rd[0]), .RESP_ERR(re[0])
    );
    core_dmem_resp #(.ADDR_W(12), .LATENCY(3)) d3 (
        .CLK(clk), .RST(rst), .REQ_VALID(v[1]), .REQ_READY(rdy[1]), .REQ_ADDR(a[1]),
        .REQ_WE(we[1]), .REQ_SIZE(sz[1]), .REQ_UNSIGNED(un[1]), .REQ_WDATA(wd[1]),
        .RESP_VALID(rv[1]), .RESP_RDATA(rd[1]), .RESP_ERR(re[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic mon(input int s, input exp_t e);
        chk($sformatf("rdata%0d", s), rd[s], e.d);
        chk($sformatf("err%0d", s), 32'(re[s]), 32'(e.e));
        chk($sformatf("cycle%0d", s), 32'(cyc), 32'(e.c));
    endtask

    always @(negedge clk) begin
        if (rv[0]) begin
            if (q0.size() == 0) chk("unexpected_resp0", 32'd1, 32'd0);
            else mon(0, q0.pop_front());
        end
        if (rv[1]) begin
            if (q1.size() == 0) chk("unexpected_resp1", 32'd1, 32'd0);
            else mon(1, q1.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with REQ_VALID dropped.
    task automatic issue(input int s, input logic w, input logic [1:0] size, input logic u,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] ed, input logic ee, input bit push, input int ew);
        int n = 0;
        exp_t e;
        we[s] = w; sz[s] = size; un[s] = u; a[s] = addr; wd[s] = wdata; v[s] = 1'b1;
        while (!rdy[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[s]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            v[s] = 1'b0;
            return;
        end
        if (ew >= 0) chk($sformatf("ready_gap%0d", s), 32'(n), 32'(ew));
        e.d = ed; e.e = ee; e.c = cyc + 3 + (s == 1 ? 3 : 0);
        if (push) begin
            if (s == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(negedge clk);
        v[s] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; we[i] = 0; un[i] = 0; sz[i] = 0; a[i] = 0; wd[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_ready0", 32'(rdy[0]), 32'd0);
        chk("reset_ready1", 32'(rdy[1]), 32'd0);
        chk("reset_valid", 32'({rv[0], rv[1]}), 32'd0);
        chk("reset_rdata", rd[0] | rd[1], 32'd0);
        chk("reset_err", 32'({re[0], re[1]}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'({rdy[0], rdy[1]}), 32'd3);

        issue(0, 1, 2'b10, 0, 32'h100, 32'h11223344, 32'h0, 0, 1, 0);
        issue(0, 0, 2'b10, 0, 32'h100, 32'h0, 32'h11223344, 0, 1, 2);
        issue(0, 1, 2'b00, 0, 32'h102, 32'hAAAAAAAA, 32'h0, 0, 1, 2);
        issue(0, 0, 2'b00, 0, 32'h102, 32'h0, 32'hFFFFFFAA, 0, 1, 2);
        issue(0, 0, 2'b00, 1, 32'h102, 32'h0, 32'h000000AA, 0, 1, 2);
        issue(0, 0, 2'b10, 0, 32'h100, 32'h0, 32'h11AA3344, 0, 1, 2);
        issue(0, 0, 2'b00, 0, 32'h103, 32'h0, 32'h00000011, 0, 1, -1);
        issue(0, 0, 2'b01, 0, 32'h100, 32'h0, 32'h00003344, 0, 1, -1);
        issue(0, 0, 2'b01, 1, 32'h102, 32'h0, 32'h000011AA, 0, 1, -1);
        issue(0, 1, 2'b10, 0, 32'h104, 32'h00000000, 32'h0, 0, 1, -1);
        issue(0, 1, 2'b01, 0, 32'h106, 32'h80018001, 32'h0, 0, 1, -1);
        issue(0, 0, 2'b01, 0, 32'h106, 32'h0, 32'hFFFF8001, 0, 1, -1);
        issue(0, 0, 2'b01, 1, 32'h106, 32'h0, 32'h00008001, 0, 1, -1);
        issue(0, 0, 2'b01, 0, 32'h105, 32'h0, 32'h0, 1, 1, -1);
        issue(0, 1, 2'b01, 0, 32'h105, 32'hFFFFFFFF, 32'h0, 1, 1, -1);
        issue(0, 0, 2'b10, 0, 32'h104, 32'h0, 32'h80010000, 0, 1, -1);
        issue(0, 0, 2'b10, 0, 32'h00010000, 32'h0, 32'h0, 1, 1, -1);
        issue(0, 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 1, 1, -1);
        issue(0, 1, 2'b10, 0, 32'h101, 32'hFFFFFFFF, 32'h0, 1, 1, -1);
        issue(0, 1, 2'b10, 0, 32'h00004100, 32'hFFFFFFFF, 32'h0, 1, 1, -1);
        issue(0, 0, 2'b10, 0, 32'h100, 32'h0, 32'h11AA3344, 0, 1, -1);
        drain();

        issue(1, 1, 2'b10, 0, 32'h200, 32'h12345678, 32'h0, 0, 1, 0);
        issue(1, 0, 2'b10, 0, 32'h200, 32'h0, 32'h12345678, 0, 1, 5);
        issue(1, 0, 2'b01, 1, 32'h202, 32'h0, 32'h00001234, 0, 1, 5);
        drain();

        issue(1, 1, 2'b10, 0, 32'h200, 32'hDEADBEEF, 32'h0, 0, 0, -1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_ready", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_midreset_ready", 32'(rdy[1]), 32'd1);
        repeat (8) @(negedge clk);
        issue(1, 0, 2'b10, 0, 32'h200, 32'h0, 32'h12345678, 0, 1, -1);
        drain();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
